// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator that rebuilds OUT_W-bit samples from the 1-bit delta-sigma stream.
// Define DSM_CIC_UNSIGNED_EN to emit offset-binary (modulator vin format) instead of signed output.
module dsm_cic_decimator #(
    parameter int DECIM = 64,
    parameter int ORDER = 3,
    parameter int OUT_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwm,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int CNT_W = $clog2(DECIM);

    if (ORDER != 3 || OUT_W < 2 + ORDER * CNT_W || (1 << CNT_W) != DECIM) begin : g_bad_cfg
        $error("dsm_cic_decimator: unsupported DECIM/ORDER/OUT_W combination");
    end

    logic [OUT_W-1:0] r_int1, r_int2, r_int3;
    logic [OUT_W-1:0] r_d1, r_d2, r_d3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dump;

    logic [OUT_W-1:0] w_sample;
    logic [OUT_W-1:0] w_int1_nxt, w_int2_nxt, w_int3_nxt;
    logic [OUT_W-1:0] w_c1, w_c2, w_c3;
    logic [OUT_W-1:0] w_result;
    logic             w_last;

    // Integrators are chained within one cycle so integrator 3 already holds the newest sample.
    always_comb begin
        w_sample   = pwm ? OUT_W'(1) : {OUT_W{1'b1}};
        w_int1_nxt = r_int1 + w_sample;
        w_int2_nxt = r_int2 + w_int1_nxt;
        w_int3_nxt = r_int3 + w_int2_nxt;
        w_last     = (r_cnt == CNT_W'(DECIM - 1));
        w_c1       = r_int3 - r_d1;
        w_c2       = w_c1 - r_d2;
        w_c3       = w_c2 - r_d3;
    end

`ifdef DSM_CIC_UNSIGNED_EN
    logic signed [OUT_W+1:0] w_wide;

    // 2*y + half-scale, then clamp to the unsigned OUT_W range.
    always_comb begin
        w_wide = $signed({w_c3[OUT_W-1], w_c3, 1'b0})
               + $signed({2'b00, 1'b1, {(OUT_W-1){1'b0}}});
        if (w_wide[OUT_W+1]) begin
            w_result = '0;
        end else if (w_wide[OUT_W]) begin
            w_result = '1;
        end else begin
            w_result = w_wide[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        w_result = w_c3;
    end
`endif

    // NOTE: every register here uses <= so all stages see pre-edge values, giving a clean pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_int1    <= '0;
            r_int2    <= '0;
            r_int3    <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_cnt     <= '0;
            r_dump    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_int1 <= w_int1_nxt;
                r_int2 <= w_int2_nxt;
                r_int3 <= w_int3_nxt;
                r_cnt  <= r_cnt + CNT_W'(1);
                r_dump <= w_last;
            end else begin
                r_dump <= 1'b0;
            end

            // A dump always wins over consumption; overwriting an unconsumed sample is flagged.
            if (r_dump) begin
                r_d1      <= r_int3;
                r_d2      <= w_c1;
                r_d3      <= w_c2;
                out_data  <= w_result;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Self-checking bench for dsm_cic_decimator: kernel-convolution reference model plus directed vectors.
module tb_dsm_cic_decimator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pwm = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    dsm_cic_decimator #(.DECIM(64), .ORDER(3), .OUT_W(20)) dut (
        .clock    (clock),
        .reset    (reset),
        .pwm      (pwm),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    // Reference: impulse response of three cascaded 64-tap boxcars, applied to the accepted-sample history.
    int hk[190];
    int xs[$];
    int n_acc = 0;
    bit m_dump = 1'b0;
    int e_data = 0;
    bit e_valid = 1'b0;
    bit e_ovr = 1'b0;
    int cap[$];
    int mcap[$];

    function automatic int fmt(input int y);
`ifdef DSM_CIC_UNSIGNED_EN
        int v;
        v = 2 * y + 524288;
        if (v < 0) v = 0;
        if (v > 1048575) v = 1048575;
        return v;
`else
        return y & 32'h000F_FFFF;
`endif
    endfunction

    function automatic int model_y();
        int y;
        int idx;
        y = 0;
        for (int j = 0; j < 190; j++) begin
            idx = xs.size() - 1 - j;
            if (idx >= 0) y += hk[j] * xs[idx];
        end
        return y;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            xs.delete();
            n_acc   = 0;
            m_dump  = 1'b0;
            e_data  = 0;
            e_valid = 1'b0;
            e_ovr   = 1'b0;
        end else begin
            if (m_dump) begin
                if (e_valid && !out_ready) e_ovr = 1'b1;
                e_data  = fmt(model_y());
                e_valid = 1'b1;
            end else if (e_valid && out_ready) begin
                e_valid = 1'b0;
            end
            if (in_valid) begin
                xs.push_back(pwm ? 1 : -1);
                if (xs.size() > 256) void'(xs.pop_front());
                n_acc++;
                m_dump = (n_acc % 64 == 0);
            end else begin
                m_dump = 1'b0;
            end
        end
    endtask

    initial begin
        int b2[127];
        for (int k = 0; k < 127; k++) b2[k] = 0;
        for (int k = 0; k < 190; k++) hk[k] = 0;
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++) b2[a+b]++;
        for (int k = 0; k < 127; k++)
            for (int c = 0; c < 64; c++) hk[k+c] += b2[k];
        forever begin
            @(posedge clock or negedge reset);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            check("out_valid", int'(out_valid), int'(e_valid));
            check("overrun", int'(overrun), int'(e_ovr));
            check("out_data", int'(out_data), e_data);
            if (out_valid && out_ready) begin
                cap.push_back(int'(out_data));
                mcap.push_back(e_data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        cap.delete();
        mcap.delete();
    endtask

    // mode 0: pwm=1, 1: pwm=0, 2: alternate 1,0, 3: pwm=1 with in_valid toggling
    task automatic drive(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            case (mode)
                0: begin pwm = 1'b1; in_valid = 1'b1; end
                1: begin pwm = 1'b0; in_valid = 1'b1; end
                2: begin pwm = (i % 2 == 0); in_valid = 1'b1; end
                default: begin pwm = 1'b1; in_valid = (i % 2 == 0); end
            endcase
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic pin_outputs(input string tag, input int first, input int second, input int steady,
                               input bit pin_fill);
        check({tag, "_count"}, int'(cap.size() >= 10), 1);
        if (pin_fill) begin
            check({tag, "_out1"}, cap[0], first);
            check({tag, "_out2"}, cap[1], second);
            check({tag, "_model_out1"}, mcap[0], first);
        end
        for (int k = 2; k < 10; k++) begin
            check($sformatf("%s_out%0d", tag, k + 1), cap[k], steady);
            check($sformatf("%s_model_out%0d", tag, k + 1), mcap[k], steady);
        end
    endtask

    int v_p1, v_p2, v_ps, v_n1, v_n2, v_ns, v_z;

    initial begin
`ifdef DSM_CIC_UNSIGNED_EN
        v_p1 = 615808; v_p2 = 965248; v_ps = 1048575;
        v_n1 = 432768; v_n2 = 83328;  v_ns = 0;
        v_z  = 524288;
`else
        v_p1 = 45760;  v_p2 = 220480; v_ps = 262144;
        v_n1 = 32'h000F_FFFF & -45760;
        v_n2 = 32'h000F_FFFF & -220480;
        v_ns = 32'h000F_FFFF & -262144;
        v_z  = 0;
`endif
        // Reset held, then released idle.
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #2;
        check("idle_valid", int'(out_valid), 0);
        check("idle_data", int'(out_data), 0);
        check("idle_overrun", int'(overrun), 0);

        out_ready = 1'b1;
        do_reset();
        drive(10 * 64 + 3, 0);
        pin_outputs("pos", v_p1, v_p2, v_ps, 1'b1);

        do_reset();
        drive(10 * 64 + 3, 1);
        pin_outputs("neg", v_n1, v_n2, v_ns, 1'b1);

        do_reset();
        drive(10 * 64 + 3, 2);
        pin_outputs("alt", 0, 0, v_z, 1'b0);

        do_reset();
        drive(10 * 128 + 6, 3);
        pin_outputs("gap", v_p1, v_p2, v_ps, 1'b1);

        // Two dumps with no consumer: second result overwrites and overrun sticks.
        out_ready = 1'b0;
        do_reset();
        drive(128 + 1, 0);
        #1;
        check("ovr_valid", int'(out_valid), 1);
        check("ovr_data", int'(out_data), v_p2);
        check("ovr_flag", int'(overrun), 1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("ovr_consumed_valid", int'(out_valid), 0);
        check("ovr_sticky", int'(overrun), 1);

        // Reset at accepted sample 40 of the third frame.
        do_reset();
        for (int i = 0; i < 2 * 64 + 40; i++) begin
            @(posedge clock);
            #1;
            pwm = 1'b1;
            in_valid = 1'b1;
        end
        @(posedge clock);
        #2;
        in_valid = 1'b0;
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_overrun", int'(overrun), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        cap.delete();
        mcap.delete();
        out_ready = 1'b1;
        drive(3 * 64 + 4, 0);
        check("post_rst_count", int'(cap.size() >= 3), 1);
        check("post_rst_out1", cap[0], v_p1);
        check("post_rst_out2", cap[1], v_p2);
        check("post_rst_out3", cap[2], v_ps);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsm_cic_decimator.md
Name: dsm_cic_decimator

Overview:
- Downstream stage of the delta-sigma modulator.
- Consumes the modulator's 1-bit pwm stream and reconstructs 20-bit samples with a 3rd-order CIC decimator (decimation factor DECIM).
- Used on-chip as a loopback/monitor path, so software can compare the reconstructed samples against the vin it drove.
- Presents results through a valid/ready output with a one-entry holding register and a sticky overrun flag.

Parameters:
- DECIM, 64, decimation ratio. Must be a power of two; only 64 is supported for OUT_W=20.
- ORDER, 3, number of integrator/comb sections. Fixed at 3; the parameter exists for documentation and checking only.
- OUT_W, 20, output and accumulator width. Must satisfy OUT_W >= 2 + ORDER*log2(DECIM).

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- pwm  in  1  modulator bitstream; 1 = +1, 0 = -1
- in_valid  in  1  qualifies pwm; the sample is accepted on a rising edge with in_valid=1
- out_data  out  OUT_W  decimated sample; signed two's complement by default
- out_valid  out  1  out_data holds an unconsumed sample
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- overrun  out  1  sticky flag: an unconsumed sample was overwritten

Behaviour:
- Reset (reset=0, asynchronous): integrators, comb delay registers, decimation counter, out_data, out_valid and overrun all go to 0. Reset mid-frame discards the partial frame; counting restarts at 0 after release.
- Input mapping: pwm=1 -> +1, pwm=0 -> -1, sign-extended to OUT_W.
- Integrators: three cascaded OUT_W-bit accumulators, updated only on accepted samples. Modulo-2^OUT_W wrap-around is required and intentional; no saturation.
- Decimation counter: counts accepted samples 0..DECIM-1 and wraps to 0. The edge that accepts the DECIM-th sample (counter == DECIM-1) registers a one-cycle dump strobe.
- Combs: on the edge where the strobe is high, three cascaded combs with differential delay 1 at the decimated rate (y = x - x_prev, modulo 2^OUT_W) produce the result. The combs take the integrator-3 value, which already includes the DECIM-th sample.
- Latency: the result is written to out_data, and out_valid is set, on the edge immediately after the edge that accepted the DECIM-th sample.
- Gain: DECIM^ORDER = 2^18. Constant input gives out_data = ±262144 from the 3rd output onward; outputs 1-2 are the filter fill transient.
- Handshake: out_valid && out_ready on an edge consumes the sample; out_valid clears unless a new result is written on the same edge.
- New result on the same edge as consumption: out_data updates, out_valid stays 1, no overrun.
- New result while out_valid=1 and out_ready=0: out_data is overwritten, out_valid stays 1, overrun sets to 1 and holds until reset.
- in_valid=0: the pipeline holds. A pending dump strobe still completes on the next edge.
- out_data is stable while out_valid=1, except for the overwrite case above.

Optional Feature:
- Macro: DSM_CIC_UNSIGNED_EN.
- Defined: out_data is offset-binary in the same format as the modulator's vin: out_data = clamp(2*y + 524288, 0, 1048575), where y is the signed comb result. Conversion adds no extra cycle of latency.
- Undefined: out_data = y, signed two's complement. No clamp logic is present.

Test Plan:
- Reset held 3 cycles, then released with in_valid=0 for 10 cycles -> out_data=0, out_valid=0, overrun=0 throughout.
- pwm=1 constantly, in_valid=1, out_ready=1 -> out_valid pulses every 64 cycles, 1 cycle after each 64th sample. Outputs 3..10 = 262144 (1048575 with DSM_CIC_UNSIGNED_EN).
- pwm=0 constantly -> outputs 3..10 = -262144 (0 with DSM_CIC_UNSIGNED_EN). Alternating 1,0 -> outputs 3..10 = 0 (524288 with the macro).
- pwm=1 constantly with in_valid toggling 1,0 -> outputs every 128 cycles, identical values to the continuous case.
- out_ready=0 across two dump events -> out_valid stays 1, out_data shows the second result, overrun=1. Raising out_ready for 1 cycle -> out_valid=0, overrun stays 1.
- reset pulsed low at accepted-sample 40 of a frame -> all outputs 0 immediately. After release, the first out_valid arrives 64 accepted samples later, with fill-transient values matching a fresh start.
